// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine sequencer.
// State encoding, mode codes, remaining-time width, phase length helper.
package wm_pkg;

    localparam int REM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WASH  = 3'd1,
        ST_RINSE = 3'd2,
        ST_SPIN  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] MODE_QUICK = 2'd0;
    localparam logic [1:0] MODE_STD   = 2'd1;
    localparam logic [1:0] MODE_HEAVY = 2'd2;

    // base seconds scaled by (mode+1), kept in REM_W bits
    function automatic logic [REM_W-1:0] phase_len(
        input logic [REM_W-1:0] base,
        input logic [1:0]       m
    );
        logic [REM_W-1:0] mul;
        mul = REM_W'(m) + 1'b1;
        return base * mul;
    endfunction

endpackage

// File: rtl/wm_sec_tick.sv
// Millisecond counter producing a one-cycle 1 s tick.
// In: clk, rst, clkCnt_1msEnd, run (count enable), clr. Out: sec_tick.
module wm_sec_tick #(
    parameter int MS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clkCnt_1msEnd,
    input  logic run,
    input  logic clr,
    output logic sec_tick
);

    localparam int CW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [CW-1:0] MS_LAST = CW'(MS_PER_SEC - 1);

    logic [CW-1:0] ms_q;
    logic [CW-1:0] ms_d;

    assign sec_tick = clkCnt_1msEnd & run & (ms_q == MS_LAST);

    always_comb begin
        ms_d = ms_q;
        if (clr) begin
            ms_d = '0;
        end else if (run && clkCnt_1msEnd) begin
            ms_d = (ms_q == MS_LAST) ? '0 : ms_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ms_q <= '0;
        else     ms_q <= ms_d;
    end

endmodule

// File: rtl/wm_seq.sv
// Washing-machine program sequencer: wash, rinse, spin, done, with pause.
// In: clk, rst, clkCnt_1msEnd, start_en, mode_en. Out: mode, state, rem_sec, enables.
module wm_seq
    import wm_pkg::*;
#(
    parameter int MS_PER_SEC   = 1000,
    parameter int BASE_WASH_S  = 20,
    parameter int BASE_RINSE_S = 10,
    parameter int BASE_SPIN_S  = 10,
    parameter int DONE_S       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkCnt_1msEnd,
    input  logic             start_en,
    input  logic             mode_en,
    output logic [1:0]       mode,
    output logic [2:0]       state,
    output logic [REM_W-1:0] rem_sec,
    output logic             motor_on,
    output logic             spin_fast,
    output logic             valve_in,
    output logic             drain,
    output logic             buzz
);

    localparam logic [REM_W-1:0] WASH_B  = REM_W'(BASE_WASH_S);
    localparam logic [REM_W-1:0] RINSE_B = REM_W'(BASE_RINSE_S);
    localparam logic [REM_W-1:0] SPIN_B  = REM_W'(BASE_SPIN_S);
    localparam logic [REM_W-1:0] DONE_T  = REM_W'(DONE_S);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    logic [1:0]       mode_q, mode_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             motor_q, spin_q, valve_q, drain_q, buzz_q;
    logic             run, clr, sec_tick;

    assign run = (state_q == ST_WASH) || (state_q == ST_RINSE) ||
                 (state_q == ST_SPIN) || (state_q == ST_DONE);

    // restart the second on every phase entry; pause/resume keep it
    assign clr = (state_d != state_q) &&
                 (state_d != ST_PAUSE) && (state_q != ST_PAUSE);

    wm_sec_tick #(
        .MS_PER_SEC(MS_PER_SEC)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .clkCnt_1msEnd(clkCnt_1msEnd),
        .run          (run),
        .clr          (clr),
        .sec_tick     (sec_tick)
    );

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_en) begin
                    state_d = ST_WASH;
                    rem_d   = phase_len(WASH_B, mode_q);
                end else if (mode_en) begin
                    mode_d = (mode_q == MODE_HEAVY) ? MODE_QUICK
                                                    : mode_q + 2'd1;
                end
            end
            ST_WASH, ST_RINSE, ST_SPIN: begin
                if (start_en) begin
                    ret_d   = state_q;
                    state_d = ST_PAUSE;
                end else if (sec_tick) begin
                    if (rem_q > 1) begin
                        rem_d = rem_q - 1'b1;
                    end else if (state_q == ST_WASH) begin
                        state_d = ST_RINSE;
                        rem_d   = phase_len(RINSE_B, mode_q);
                    end else if (state_q == ST_RINSE) begin
                        state_d = ST_SPIN;
                        rem_d   = phase_len(SPIN_B, mode_q);
                    end else begin
                        state_d = ST_DONE;
                        rem_d   = DONE_T;
                    end
                end
            end
            ST_PAUSE: begin
                if (start_en) state_d = ret_q;
            end
            ST_DONE: begin
                if (start_en) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else if (sec_tick) begin
                    if (rem_q > 1) begin
                        rem_d = rem_q - 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        rem_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            mode_q  <= MODE_QUICK;
            rem_q   <= '0;
            motor_q <= 1'b0;
            spin_q  <= 1'b0;
            valve_q <= 1'b0;
            drain_q <= 1'b0;
            buzz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            // decoded from next state so enables move with state
            motor_q <= (state_d == ST_WASH) || (state_d == ST_RINSE) ||
                       (state_d == ST_SPIN);
            spin_q  <= (state_d == ST_SPIN);
            valve_q <= (state_d == ST_WASH) || (state_d == ST_RINSE);
            drain_q <= (state_d == ST_SPIN);
            buzz_q  <= (state_d == ST_DONE);
        end
    end

    assign state     = state_q;
    assign mode      = mode_q;
    assign rem_sec   = rem_q;
    assign motor_on  = motor_q;
    assign spin_fast = spin_q;
    assign valve_in  = valve_q;
    assign drain     = drain_q;
    assign buzz      = buzz_q;

endmodule

// File: tb/tb_wm_seq.sv
// Directed bench for wm_seq with a 4 ms second.
// Expected snapshots are queued per driven cycle and checked after the edge.
module tb_wm_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clkCnt_1msEnd = 1'b0;
    logic       start_en = 1'b0;
    logic       mode_en = 1'b0;
    logic [1:0] mode;
    logic [2:0] state;
    logic [7:0] rem_sec;
    logic       motor_on, spin_fast, valve_in, drain, buzz;

    localparam logic [4:0] EN_OFF = 5'b00000;
    localparam logic [4:0] EN_WR  = 5'b10100;
    localparam logic [4:0] EN_SP  = 5'b11010;
    localparam logic [4:0] EN_DN  = 5'b00001;

    typedef struct {
        string       tag;
        logic [17:0] val;
    } exp_t;

    exp_t sb[$];
    int   errs = 0;
    int   checks = 0;

    wm_seq #(
        .MS_PER_SEC(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clkCnt_1msEnd(clkCnt_1msEnd),
        .start_en     (start_en),
        .mode_en      (mode_en),
        .mode         (mode),
        .state        (state),
        .rem_sec      (rem_sec),
        .motor_on     (motor_on),
        .spin_fast    (spin_fast),
        .valve_in     (valve_in),
        .drain        (drain),
        .buzz         (buzz)
    );

    always #5 clk = ~clk;

    task automatic cyc(
        input logic       r,
        input logic       t,
        input logic       s,
        input logic       m,
        input string      tag,
        input logic [2:0] st,
        input logic [1:0] md,
        input logic [7:0] rm,
        input logic [4:0] en
    );
        exp_t        e;
        logic [17:0] obs;
        rst = r;
        clkCnt_1msEnd = t;
        start_en = s;
        mode_en = m;
        sb.push_back('{tag, {st, md, rm, en}});
        @(posedge clk);
        #1;
        rst = 1'b0;
        clkCnt_1msEnd = 1'b0;
        start_en = 1'b0;
        mode_en = 1'b0;
        obs = {state, mode, rem_sec,
               motor_on, spin_fast, valve_in, drain, buzz};
        checks++;
        if (sb.size() == 0) begin
            errs++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errs++;
                $error("FAIL %s: got st=%0d md=%0d rem=%0d en=%b want st=%0d md=%0d rem=%0d en=%b",
                       e.tag, obs[17:15], obs[14:13], obs[12:5], obs[4:0],
                       e.val[17:15], e.val[14:13], e.val[12:5], e.val[4:0]);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            clkCnt_1msEnd = 1'b1;
            @(posedge clk);
            #1;
            clkCnt_1msEnd = 1'b0;
        end
    endtask

    initial begin
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, "reset", 0, 0, 0, EN_OFF);

        cyc(0, 0, 0, 1, "mode1", 0, 1, 0, EN_OFF);
        cyc(0, 0, 0, 1, "mode2", 0, 2, 0, EN_OFF);
        cyc(0, 0, 0, 1, "mode0", 0, 0, 0, EN_OFF);
        cyc(0, 0, 0, 1, "mode1b", 0, 1, 0, EN_OFF);
        cyc(0, 0, 0, 1, "mode2b", 0, 2, 0, EN_OFF);
        cyc(0, 0, 0, 1, "mode0b", 0, 0, 0, EN_OFF);

        cyc(0, 0, 1, 0, "q_start", 1, 0, 20, EN_WR);
        ticks(79);
        cyc(0, 0, 0, 0, "q_wash_last", 1, 0, 1, EN_WR);
        cyc(0, 1, 0, 0, "q_rinse", 2, 0, 10, EN_WR);
        ticks(39);
        cyc(0, 0, 0, 0, "q_rinse_last", 2, 0, 1, EN_WR);
        cyc(0, 1, 0, 0, "q_spin", 3, 0, 10, EN_SP);
        ticks(39);
        cyc(0, 0, 0, 0, "q_spin_last", 3, 0, 1, EN_SP);
        cyc(0, 1, 0, 0, "q_done", 5, 0, 3, EN_DN);
        ticks(11);
        cyc(0, 0, 0, 0, "q_done_last", 5, 0, 1, EN_DN);
        cyc(0, 1, 0, 0, "q_idle", 0, 0, 0, EN_OFF);

        cyc(0, 0, 0, 1, "h_mode1", 0, 1, 0, EN_OFF);
        cyc(0, 0, 0, 1, "h_mode2", 0, 2, 0, EN_OFF);
        cyc(0, 0, 1, 0, "h_start", 1, 2, 60, EN_WR);
        ticks(8);
        cyc(0, 0, 0, 0, "h_58", 1, 2, 58, EN_WR);
        cyc(0, 0, 1, 0, "h_pause", 4, 2, 58, EN_OFF);
        ticks(20);
        cyc(0, 1, 0, 1, "h_pause_hold", 4, 2, 58, EN_OFF);
        cyc(0, 0, 1, 0, "h_resume", 1, 2, 58, EN_WR);
        ticks(3);
        cyc(0, 0, 0, 0, "h_3ticks", 1, 2, 58, EN_WR);
        cyc(0, 1, 0, 0, "h_4ticks", 1, 2, 57, EN_WR);
        cyc(1, 0, 0, 0, "h_rst", 0, 0, 0, EN_OFF);

        cyc(0, 0, 1, 0, "c_start", 1, 0, 20, EN_WR);
        ticks(80);
        cyc(0, 0, 0, 0, "c_rinse", 2, 0, 10, EN_WR);
        ticks(20);
        cyc(0, 0, 0, 0, "c_rinse5", 2, 0, 5, EN_WR);
        ticks(3);
        cyc(0, 1, 1, 0, "c_pause_tick", 4, 0, 5, EN_OFF);
        cyc(0, 0, 1, 0, "c_resume", 2, 0, 5, EN_WR);
        ticks(3);
        cyc(0, 0, 0, 0, "c_3ticks", 2, 0, 5, EN_WR);
        cyc(0, 1, 0, 0, "c_4ticks", 2, 0, 4, EN_WR);
        ticks(15);
        cyc(0, 1, 0, 0, "c_spin", 3, 0, 10, EN_SP);
        cyc(1, 0, 0, 0, "c_rst_spin", 0, 0, 0, EN_OFF);

        cyc(0, 0, 0, 1, "s_mode1", 0, 1, 0, EN_OFF);
        cyc(0, 0, 1, 1, "s_both", 1, 1, 40, EN_WR);
        cyc(0, 0, 0, 1, "s_mode_wash", 1, 1, 40, EN_WR);
        ticks(159);
        cyc(0, 0, 0, 0, "s_wash_last", 1, 1, 1, EN_WR);
        cyc(0, 1, 0, 0, "s_rinse", 2, 1, 20, EN_WR);
        ticks(79);
        cyc(0, 1, 0, 0, "s_spin", 3, 1, 20, EN_SP);
        ticks(79);
        cyc(0, 1, 0, 0, "s_done", 5, 1, 3, EN_DN);
        cyc(0, 0, 0, 1, "s_mode_done", 5, 1, 3, EN_DN);
        cyc(0, 0, 1, 0, "s_done_abort", 0, 1, 0, EN_OFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
